// File: rtl/even_parity_checker_rx.sv
// Serial even-parity frame receiver with a one-entry valid/ready output buffer.
// Optional errored-frame counter (err_clr/err_cnt) enabled by PAR_ERR_CNT_EN.
module even_parity_checker_rx #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              abort,
  output logic [DATA_W-1:0] data_out,
  output logic              par_out,
  output logic              parity_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              busy
`ifdef PAR_ERR_CNT_EN
  ,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  localparam int IDX_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic [DATA_W-1:0] sh_q, sh_d, sh_nxt;
  logic [DATA_W:0]   sh_ext;
  logic              acc_q, acc_d;
  logic              busy_d;

  logic              done;
  logic              frame_err;
  logic              load;
  logic              drop;
  logic              valid_d;

  // First bit received ends up in the MSB after DATA_W shifts.
  assign sh_ext  = {sh_q, bit_in};
  assign sh_nxt  = sh_ext[DATA_W-1:0];
  assign idx_inc = idx_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    done      = 1'b0;
    frame_err = acc_q ^ bit_in;
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      sh_d    = '0;
      acc_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bit_valid) begin
            sh_d    = sh_nxt;
            acc_d   = bit_in;
            idx_d   = IDX_W'(1);
            state_d = (DATA_W == 1) ? PAR : DATA;
          end
        end
        DATA: begin
          if (bit_valid) begin
            sh_d  = sh_nxt;
            acc_d = acc_q ^ bit_in;
            idx_d = idx_inc;
            if (idx_inc == IDX_W'(DATA_W)) begin
              state_d = PAR;
            end
          end
        end
        PAR: begin
          if (bit_valid) begin
            done    = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
            sh_d    = '0;
            acc_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          sh_d    = '0;
          acc_d   = 1'b0;
        end
      endcase
    end
  end

  assign busy_d = (state_d != IDLE);

  // A completed frame only enters the buffer if it is empty or draining now.
  assign load = done & (~out_valid | out_ready);
  assign drop = done & out_valid & ~out_ready;

  always_comb begin
    valid_d = out_valid;
    if (load) begin
      valid_d = 1'b1;
    end else if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      acc_q   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      busy    <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      par_out    <= 1'b0;
      parity_err <= 1'b0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= valid_d;
      overrun   <= drop;
      if (load) begin
        data_out   <= sh_q;
        par_out    <= bit_in;
        parity_err <= frame_err;
      end
    end
  end

`ifdef PAR_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (load && frame_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_even_parity_checker_rx.sv
// Directed self-checking bench for even_parity_checker_rx (DATA_W=3).
// Counter scenario runs only when PAR_ERR_CNT_EN is defined.
module tb_even_parity_checker_rx;

  localparam int DATA_W = 3;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst_n;
  logic              bit_in;
  logic              bit_valid;
  logic              abort;
  logic [DATA_W-1:0] data_out;
  logic              par_out;
  logic              parity_err;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;
  logic              busy;
`ifdef PAR_ERR_CNT_EN
  logic              err_clr;
  logic [CNT_W-1:0]  err_cnt;
`endif

  int checks;
  int failures;

  even_parity_checker_rx #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .abort     (abort),
    .data_out  (data_out),
    .par_out   (par_out),
    .parity_err(parity_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .busy      (busy)
`ifdef PAR_ERR_CNT_EN
    ,
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] w, input logic p);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      send_bit(w[i]);
    end
    send_bit(p);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
`ifdef PAR_ERR_CNT_EN
    err_clr   = 1'b0;
`endif
    #2;
    checks++;
    if ({out_valid, data_out, par_out, parity_err, overrun, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%b p=%b e=%b o=%b b=%b want all 0",
               out_valid, data_out, par_out, parity_err, overrun, busy);
    end
`ifdef PAR_ERR_CNT_EN
    checks++;
    if (err_cnt !== '0) begin
      failures++;
      $display("FAIL reset_err_cnt got %0d want 0", err_cnt);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    send_bit(1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got %b want 1", busy);
    end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 3'b101 ||
        par_out !== 1'b0 || parity_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_frame got v=%b d=%b p=%b e=%b want 1 101 0 0",
               out_valid, data_out, par_out, parity_err);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle_busy got %b want 0", busy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_parity_error();
    send_frame(3'b011, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 3'b011 ||
        par_out !== 1'b1 || parity_err !== 1'b1) begin
      failures++;
      $display("FAIL perr_frame got v=%b d=%b p=%b e=%b want 1 011 1 1",
               out_valid, data_out, par_out, parity_err);
    end
    tick();
  endtask

  task automatic test_all_words();
    logic [2:0] w;
    logic [2:0] pv;
    // even parity bits for words 0..7, hand-computed
    pv = 3'b0;
    for (int i = 0; i < 8; i++) begin
      w = 3'(i);
      case (i)
        0, 3, 5, 6: pv[0] = 1'b0;
        default:    pv[0] = 1'b1;
      endcase
      send_frame(w, pv[0]);
      checks++;
      if (out_valid !== 1'b1 || data_out !== w || parity_err !== 1'b0 ||
          par_out !== pv[0]) begin
        failures++;
        $display("FAIL word_%0d got v=%b d=%b p=%b e=%b want 1 %b %b 0",
                 i, out_valid, data_out, par_out, parity_err, w, pv[0]);
      end
    end
    tick();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_frame(3'b110, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 3'b110) begin
      failures++;
      $display("FAIL ovr_first got v=%b d=%b want 1 110", out_valid, data_out);
    end
    send_frame(3'b001, 1'b1);
    checks++;
    if (overrun !== 1'b1 || data_out !== 3'b110 || par_out !== 1'b0) begin
      failures++;
      $display("FAIL ovr_pulse got o=%b d=%b p=%b want 1 110 0",
               overrun, data_out, par_out);
    end
    tick();
    checks++;
    if (overrun !== 1'b0 || out_valid !== 1'b1 || data_out !== 3'b110) begin
      failures++;
      $display("FAIL ovr_after got o=%b v=%b d=%b want 0 1 110",
               overrun, out_valid, data_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ovr_idle got busy=%b want 0", busy);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovr_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_abort();
    int vcount;
    send_bit(1'b1);
    send_bit(1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got busy=%b v=%b want 0 0", busy, out_valid);
    end
    abort     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    abort     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_wins got busy=%b want 0", busy);
    end
    vcount = 0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      send_bit(i == DATA_W - 1);
      if (out_valid) vcount++;
    end
    send_bit(1'b1);
    if (out_valid) vcount++;
    checks++;
    if (data_out !== 3'b100 || parity_err !== 1'b0 || par_out !== 1'b1) begin
      failures++;
      $display("FAIL abort_frame got d=%b p=%b e=%b want 100 1 0",
               data_out, par_out, parity_err);
    end
    tick();
    if (out_valid) vcount++;
    checks++;
    if (vcount != 1) begin
      failures++;
      $display("FAIL abort_count got %0d frames want 1", vcount);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send_frame(3'b111, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, data_out, par_out, parity_err, overrun, busy} !== '0) begin
      failures++;
      $display("FAIL async_rst got v=%b d=%b p=%b e=%b o=%b b=%b want all 0",
               out_valid, data_out, par_out, parity_err, overrun, busy);
    end
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    send_frame(3'b010, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 3'b010 ||
        par_out !== 1'b1 || parity_err !== 1'b0) begin
      failures++;
      $display("FAIL post_rst got v=%b d=%b p=%b e=%b want 1 010 1 0",
               out_valid, data_out, par_out, parity_err);
    end
    tick();
  endtask

`ifdef PAR_ERR_CNT_EN
  task automatic test_err_cnt();
    logic [CNT_W-1:0] exp;
    checks++;
    if (err_cnt !== 2'd0) begin
      failures++;
      $display("FAIL cnt_start got %0d want 0", err_cnt);
    end
    for (int i = 1; i <= 5; i++) begin
      exp = (i >= 3) ? 2'd3 : 2'(i);
      send_frame(3'b001, 1'b0);
      checks++;
      if (err_cnt !== exp) begin
        failures++;
        $display("FAIL cnt_%0d got %0d want %0d", i, err_cnt, exp);
      end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== 2'd0) begin
      failures++;
      $display("FAIL cnt_clear got %0d want 0", err_cnt);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_parity_error();
    test_all_words();
    test_overrun();
    test_abort();
    test_async_reset();
`ifdef PAR_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
